adv_dma_read_scheduler: RTL and testbench
=========================================

ADV_DMA_READ_SCHEDULER -- requirements
Module: adv_dma_read_scheduler

Interface
REQ-001 SHALL have parameter P_CHANNELS, default 4, number of requester channels (2..16); CW = max(1, clog2(P_CHANNELS)).
REQ-002 SHALL have ports: i_clk  in  1  sole clock, rising edge; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: req_valid  in  P_CHANNELS  descriptor offered per channel; req_ready  out  P_CHANNELS  descriptor accepted.
REQ-004 SHALL have ports: req_host_addr  in  32*P_CHANNELS; req_dev_addr  in  32*P_CHANNELS; req_len  in  32*P_CHANNELS  (bytes); channel k occupies bits [32k+31:32k].
REQ-005 SHALL have ports: dma_read_host_address  out  32; dma_read_device_address  out  32; dma_read_length  out  32; dma_read_start  out  1  (controller job programming).
REQ-006 SHALL have ports: int_valid  in  1; int_done  out  1; all_empty  in  1  (controller completion/drain status).
REQ-007 SHALL have ports: done_valid  out  1; done_ready  in  1; done_chan  out  CW; done_err  out  1; busy  out  1; job_cycles  out  32.

Function
REQ-008 SHALL implement FSM states IDLE, START, WAIT_INT, ACK, DRAIN, DONE.
REQ-009 IDLE: if any req_valid, SHALL grant round-robin starting at (last_grant+1) mod P_CHANNELS, asserting req_ready[grant] combinationally for exactly that cycle; the handshake cycle is the acceptance.
REQ-010 On acceptance SHALL register the granted descriptor into the dma_read_* address/length outputs and the grant index into done_chan; these SHALL stay stable until the return to IDLE.
REQ-011 On acceptance, if req_len==0 or req_len[1:0]!=0, SHALL go directly to DONE with done_err=1 and SHALL NOT pulse dma_read_start; otherwise go to START with done_err=0.
REQ-012 START: SHALL hold dma_read_start=1 for exactly one cycle, then go to WAIT_INT.
REQ-013 WAIT_INT: on int_valid==1, go to ACK; int_valid SHALL be ignored in every other state.
REQ-014 ACK: SHALL hold int_done=1 for exactly one cycle, then go to DRAIN.
REQ-015 DRAIN: SHALL go to DONE on the first cycle with all_empty==1, at the earliest the cycle after ACK.
REQ-016 DONE: SHALL hold done_valid=1 until done_valid && done_ready; that cycle SHALL go to IDLE and load last_grant with done_chan.
REQ-017 busy SHALL be 1 in all states except IDLE; req_ready SHALL be all-zero outside IDLE.
REQ-018 Round-robin SHALL be starvation-free: a continuously valid channel SHALL be granted within P_CHANNELS jobs.
REQ-019 req_valid deasserting in a non-IDLE state SHALL have no effect; the latched descriptor SHALL be used.
REQ-020 A job SHALL take at least 5 cycles from acceptance to done_valid (START, WAIT_INT, ACK, DRAIN, DONE), with no gap cycles between the states beyond those waits.

Reset
REQ-021 While i_rst_n==0, SHALL asynchronously force: state=IDLE, last_grant=P_CHANNELS-1 (so channel 0 wins first), and all outputs to 0.
REQ-022 Reset asserted mid-job SHALL abandon the job with no done_valid; first grant after release SHALL be channel 0 when req_valid[0]==1.

Configuration
REQ-023 Macro ADV_DMA_READ_SCHED_PERF_EN: when defined, SHALL count cycles from acceptance (count 1) through entry to DONE, saturating at 32'hFFFF_FFFF.
REQ-024 With ADV_DMA_READ_SCHED_PERF_EN defined, job_cycles SHALL be registered at DONE entry and held until the next DONE entry.
REQ-025 With ADV_DMA_READ_SCHED_PERF_EN undefined, job_cycles SHALL be constant 0 and no counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-026 Single job: ch1 offers host 0x1000_0000, dev 0x0000_0400, len 0x200 -> one req_ready[1], one dma_read_start with those values, int_done one cycle after int_valid, done_valid with done_chan=1, done_err=0 after all_empty.
REQ-027 Fairness: all 4 req_valid held high with done_ready=1 -> grant order 0,1,2,3,0 after reset.
REQ-028 Bad length: ch2 len=0x202, then ch3 len=0 -> no dma_read_start; done_valid with done_err=1 for both, done_chan=2 then 3.
REQ-029 Backpressure: all_empty held 0 for 20 cycles after ACK, then done_ready held 0 for 10 cycles -> DRAIN holds, done_valid stays 1 with stable done_chan, no new req_ready.
REQ-030 Reset mid-job: i_rst_n low during WAIT_INT -> all outputs 0 immediately; after release with req_valid=4'b0101, channel 0 is granted first.
REQ-031 PERF_EN defined: int_valid returned 10 cycles after start, all_empty already 1 -> job_cycles=15; undefined build -> job_cycles=0.

Source files
------------

// File: rtl/adv_dma_read_scheduler.sv
// Round-robin DMA read scheduler: arbitrates per-channel descriptors, programs one controller job at a time.
// Optional per-job cycle counter enabled by defining ADV_DMA_READ_SCHED_PERF_EN.
module adv_dma_read_scheduler #(
    parameter int  P_CHANNELS = 4,
    localparam int CW         = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_CHANNELS-1:0]   req_valid,
    output logic [P_CHANNELS-1:0]   req_ready,
    input  logic [32*P_CHANNELS-1:0] req_host_addr,
    input  logic [32*P_CHANNELS-1:0] req_dev_addr,
    input  logic [32*P_CHANNELS-1:0] req_len,
    output logic [31:0]             dma_read_host_address,
    output logic [31:0]             dma_read_device_address,
    output logic [31:0]             dma_read_length,
    output logic                    dma_read_start,
    input  logic                    int_valid,
    output logic                    int_done,
    input  logic                    all_empty,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [CW-1:0]           done_chan,
    output logic                    done_err,
    output logic                    busy,
    output logic [31:0]             job_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_INT, S_ACK, S_DRAIN, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] last_grant_q;
    logic [CW-1:0] grant;
    logic          grant_found;
    logic          accept;
    logic [31:0]   sel_host, sel_dev, sel_len;
    logic          len_bad;
    logic [31:0]   host_q, dev_q, len_q;
    logic [CW-1:0] chan_q;
    logic          err_q;

    // Search starts one past the previous winner so every waiting channel gets a turn.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 1; i <= P_CHANNELS; i++) begin
            if (!grant_found && req_valid[(int'(last_grant_q) + i) % P_CHANNELS]) begin
                grant_found = 1'b1;
                grant       = CW'((int'(last_grant_q) + i) % P_CHANNELS);
            end
        end
    end

    assign accept   = i_rst_n && (state_q == S_IDLE) && grant_found;
    assign sel_host = req_host_addr[{grant, 5'd0} +: 32];
    assign sel_dev  = req_dev_addr[{grant, 5'd0} +: 32];
    assign sel_len  = req_len[{grant, 5'd0} +: 32];
    assign len_bad  = (sel_len == 32'd0) || (sel_len[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= CW'(P_CHANNELS - 1);
            host_q       <= '0;
            dev_q        <= '0;
            len_q        <= '0;
            chan_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                host_q <= sel_host;
                dev_q  <= sel_dev;
                len_q  <= sel_len;
                chan_q <= grant;
                err_q  <= len_bad;
            end
            if (state_q == S_DONE && done_ready) begin
                last_grant_q <= chan_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (accept) state_d = len_bad ? S_DONE : S_START;
            S_START:    state_d = S_WAIT_INT;
            S_WAIT_INT: if (int_valid) state_d = S_ACK;
            S_ACK:      state_d = S_DRAIN;
            S_DRAIN:    if (all_empty) state_d = S_DONE;
            S_DONE:     if (done_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        dma_read_start          = (state_q == S_START);
        int_done                = (state_q == S_ACK);
        done_valid              = (state_q == S_DONE);
        busy                    = (state_q != S_IDLE);
        dma_read_host_address   = host_q;
        dma_read_device_address = dev_q;
        dma_read_length         = len_q;
        done_chan               = chan_q;
        done_err                = err_q;
    end

`ifdef ADV_DMA_READ_SCHED_PERF_EN
    logic [31:0] cnt_q, cnt_cur, cnt_next, job_cycles_q;

    // The acceptance cycle counts as 1, so the count is seeded from IDLE.
    assign cnt_cur  = (state_q == S_IDLE) ? 32'd1 : cnt_q;
    assign cnt_next = (cnt_cur == 32'hFFFF_FFFF) ? cnt_cur : cnt_cur + 32'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            job_cycles_q <= '0;
        end else begin
            if (state_q != S_DONE) begin
                cnt_q <= cnt_next;
            end
            if (state_d == S_DONE && state_q != S_DONE) begin
                job_cycles_q <= cnt_next;
            end
        end
    end

    assign job_cycles = job_cycles_q;
`else
    assign job_cycles = '0;
`endif

endmodule

// File: tb/tb_adv_dma_read_scheduler.sv
// Scoreboard bench for adv_dma_read_scheduler: directed scenarios followed by randomized traffic.
module tb_adv_dma_read_scheduler;
    localparam int P  = 4;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [P-1:0]      rv;
    logic [P-1:0]      req_ready;
    logic [32*P-1:0]   req_host_addr, req_dev_addr, req_len;
    logic [31:0]       h_a [P];
    logic [31:0]       d_a [P];
    logic [31:0]       l_a [P];
    logic [31:0]       dma_read_host_address, dma_read_device_address, dma_read_length;
    logic              dma_read_start, int_valid, int_done, all_empty;
    logic              done_valid, done_ready, done_err, busy;
    logic [CW-1:0]     done_chan;
    logic [31:0]       job_cycles;

    adv_dma_read_scheduler #(.P_CHANNELS(P)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .req_valid(rv), .req_ready(req_ready),
        .req_host_addr(req_host_addr), .req_dev_addr(req_dev_addr), .req_len(req_len),
        .dma_read_host_address(dma_read_host_address),
        .dma_read_device_address(dma_read_device_address),
        .dma_read_length(dma_read_length), .dma_read_start(dma_read_start),
        .int_valid(int_valid), .int_done(int_done), .all_empty(all_empty),
        .done_valid(done_valid), .done_ready(done_ready), .done_chan(done_chan),
        .done_err(done_err), .busy(busy), .job_cycles(job_cycles)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < P; k++) begin
            req_host_addr[32*k +: 32] = h_a[k];
            req_dev_addr[32*k +: 32]  = d_a[k];
            req_len[32*k +: 32]       = l_a[k];
        end
    end

    typedef struct { int chan; bit err; } done_t;
    typedef struct { logic [31:0] h; logic [31:0] d; logic [31:0] l; } start_t;

    int     checks = 0;
    int     errors = 0;
    done_t  done_q[$];
    start_t start_q[$];
    int     grant_log[$];
    int     m_last;
    bit     m_busy, m_waiting, m_pend_ack;
    logic [P-1:0] acc_mask;
    bit     auto_resp, rand_ready, auto_gen, hold_valid, armed;
    int     dly;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [P-1:0] v);
        for (int i = 1; i <= P; i++) begin
            int c;
            c = (last + i) % P;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit len_is_bad(input logic [31:0] l);
        return (l == 32'd0) || (l[1:0] != 2'b00);
    endfunction

    // Reference model and monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_zero", 64'((req_ready == 0) && (dma_read_host_address == 0) &&
                (dma_read_device_address == 0) && (dma_read_length == 0) && !dma_read_start &&
                !int_done && !done_valid && (done_chan == 0) && !done_err && !busy &&
                (job_cycles == 0)), 64'd1);
            m_last = P - 1; m_busy = 0; m_waiting = 0; m_pend_ack = 0;
            done_q.delete(); start_q.delete(); acc_mask = '0;
        end else begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("int_done", 64'(int_done), 64'(m_pend_ack));
`ifndef ADV_DMA_READ_SCHED_PERF_EN
            chk("job_cycles_off", 64'(job_cycles), 64'd0);
`endif
            m_pend_ack = 0;
            if (m_waiting && int_valid) begin
                m_pend_ack = 1;
                m_waiting  = 0;
            end
            if (!m_busy && rv != 0) begin
                int g;
                done_t  e;
                start_t s;
                g = rr_pick(m_last, rv);
                chk("grant", 64'(req_ready), 64'(1) << g);
                grant_log.push_back(g);
                acc_mask[g] = 1'b1;
                e.chan = g;
                e.err  = len_is_bad(l_a[g]);
                done_q.push_back(e);
                if (!e.err) begin
                    s.h = h_a[g]; s.d = d_a[g]; s.l = l_a[g];
                    start_q.push_back(s);
                end
                m_busy = 1;
            end else begin
                chk("no_grant", 64'(req_ready), 64'd0);
            end
            if (dma_read_start) begin
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start: got start expected none at %0t", $time);
                end else begin
                    start_t s;
                    s = start_q.pop_front();
                    chk("host_addr", 64'(dma_read_host_address), 64'(s.h));
                    chk("dev_addr", 64'(dma_read_device_address), 64'(s.d));
                    chk("length", 64'(dma_read_length), 64'(s.l));
                end
                m_waiting = 1;
            end
            if (done_valid && done_ready) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected none at %0t", $time);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    chk("done_chan", 64'(done_chan), 64'(e.chan));
                    chk("done_err", 64'(done_err), 64'(e.err));
                    m_last = e.chan;
                end
                m_busy = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_valid) rv = rv & ~acc_mask;
        acc_mask = '0;
        if (auto_resp) begin
            if (m_waiting && !armed) begin
                armed = 1;
                dly   = $urandom_range(0, 5);
            end
            int_valid = 1'b0;
            if (armed) begin
                if (dly == 0) begin
                    int_valid = 1'b1;
                    armed     = 0;
                end else begin
                    dly--;
                end
            end else if ($urandom % 8 == 0) begin
                int_valid = 1'b1;
            end
            all_empty = 1'($urandom % 2);
        end
        if (rand_ready) done_ready = ($urandom % 3) != 0;
        if (auto_gen) begin
            for (int k = 0; k < P; k++) begin
                if (!rv[k] && ($urandom % 4 == 0)) begin
                    int r;
                    r = $urandom % 8;
                    h_a[k] = $urandom;
                    d_a[k] = $urandom;
                    if (r == 0)      l_a[k] = 32'd0;
                    else if (r == 1) l_a[k] = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                    else             l_a[k] = 32'($urandom_range(1, 4096)) << 2;
                    rv[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; armed = 0; int_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_quiet(input int limit);
        int n = 0;
        while ((rv != 0 || m_busy) && n < limit) begin
            tick();
            n++;
        end
        chk("quiet_within_budget", 64'(n < limit), 64'd1);
    endtask

    task automatic wait_waiting(input int limit);
        int n = 0;
        while (!m_waiting && n < limit) begin
            tick();
            n++;
        end
        chk("start_within_budget", 64'(n < limit), 64'd1);
    endtask

    task automatic set_desc(input int k, input logic [31:0] h, input logic [31:0] d, input logic [31:0] l);
        h_a[k] = h; d_a[k] = d; l_a[k] = l;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cycles;
        rst_n = 1'b0; rv = '0; int_valid = 1'b0; all_empty = 1'b0; done_ready = 1'b1;
        auto_resp = 0; rand_ready = 0; auto_gen = 0; hold_valid = 0; armed = 0; dly = 0;
        acc_mask = '0;
        for (int k = 0; k < P; k++) set_desc(k, 32'd0, 32'd0, 32'd4);
        do_reset();

        // Single job on channel 1; descriptor scrambled after acceptance must not leak through.
        set_desc(1, 32'h1000_0000, 32'h0000_0400, 32'h0000_0200);
        rv = 4'b0010;
        tick();
        set_desc(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0003);
        wait_waiting(20);
        repeat (3) tick();
        int_valid = 1'b1;
        tick();
        int_valid = 1'b0;
        tick();
        all_empty = 1'b1;
        wait_quiet(50);

        // Cycle count: interrupt 10 cycles after start, drain already empty.
        set_desc(0, 32'h2000_0000, 32'h0000_0800, 32'h0000_0040);
        rv = 4'b0001;
        wait_waiting(20);
        repeat (9) tick();
        int_valid = 1'b1;
        tick();
        int_valid = 1'b0;
        wait_quiet(50);
`ifdef ADV_DMA_READ_SCHED_PERF_EN
        exp_cycles = 32'd15;
`else
        exp_cycles = 32'd0;
`endif
        chk("job_cycles", 64'(job_cycles), 64'(exp_cycles));

        // Bad lengths complete with error and never start the controller.
        set_desc(2, 32'h3000_0000, 32'h0000_1000, 32'h0000_0202);
        rv = 4'b0100;
        wait_quiet(50);
        set_desc(3, 32'h4000_0000, 32'h0000_2000, 32'h0000_0000);
        rv = 4'b1000;
        wait_quiet(50);

        // Backpressure from drain and from done_ready, with another channel waiting.
        all_empty = 1'b0;
        set_desc(0, 32'h5000_0000, 32'h0000_3000, 32'h0000_0100);
        rv = 4'b0001;
        wait_waiting(20);
        set_desc(1, 32'h6000_0000, 32'h0000_4000, 32'h0000_0000);
        rv[1] = 1'b1;
        int_valid = 1'b1;
        tick();
        int_valid = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("drain_hold", 64'(done_valid), 64'd0);
            tick();
        end
        all_empty = 1'b1;
        done_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("done_hold_valid", 64'(done_valid), 64'd1);
            chk("done_hold_chan", 64'(done_chan), 64'd0);
            tick();
        end
        done_ready = 1'b1;
        wait_quiet(50);

        // Fairness from reset with every channel continuously requesting.
        do_reset();
        for (int k = 0; k < P; k++) set_desc(k, 32'h7000_0000 + 32'(k), 32'h100 * 32'(k), 32'h0000_0010);
        grant_log.delete();
        auto_resp = 1; hold_valid = 1; rv = 4'b1111;
        for (int n = 0; n < 500 && grant_log.size() < 5; n++) tick();
        chk("fair_count", 64'(grant_log.size() >= 5), 64'd1);
        if (grant_log.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("fair_order", 64'(grant_log[i]), 64'(i % P));
        end
        hold_valid = 0;
        wait_quiet(500);
        auto_resp = 0; int_valid = 1'b0;

        // Reset during WAIT_INT abandons the job; channel 0 wins after release.
        all_empty = 1'b0;
        set_desc(2, 32'h8000_0000, 32'h0000_5000, 32'h0000_0080);
        rv = 4'b0100;
        wait_waiting(20);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_reset", 64'(!busy && !done_valid && !dma_read_start && !int_done &&
            (dma_read_host_address == 0) && (dma_read_length == 0) && (done_chan == 0)), 64'd1);
        set_desc(0, 32'h9000_0000, 32'h0000_6000, 32'h0000_0020);
        set_desc(2, 32'hA000_0000, 32'h0000_7000, 32'h0000_0020);
        rv = 4'b0101;
        repeat (2) tick();
        grant_log.delete();
        rst_n = 1'b1;
        for (int n = 0; n < 10 && grant_log.size() < 1; n++) tick();
        chk("first_after_reset", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
        auto_resp = 1;
        wait_quiet(500);

        // Randomized traffic against the model.
        do_reset();
        auto_resp = 1; rand_ready = 1; auto_gen = 1;
        repeat (3000) tick();
        auto_gen = 0;
        wait_quiet(3000);
        rand_ready = 0; done_ready = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
